instruction_fetch: RTL

Fetch stage directly downstream of the 6-bit program counter. It drives the counter's enable and consumes the counter's address. For each address it reads one word from an internal 64-entry program memory and presents it to decode over a valid/ready handshake. It stops advancing the counter on a HALT opcode or at the end of memory.

---
 rtl/instruction_fetch.sv | 98 +++++++++
 1 files changed

// File: rtl/instruction_fetch.sv
// instruction_fetch: fetch stage between the program counter and decode.
// Drives the counter enable, reads one word per address from a 64-entry
// program memory, and issues it over a valid/ready handshake. Stops on a
// HALT opcode or after the last memory address.
// Optional feature macro: FETCH_STATS_EN enables the accepted-instruction
// counter on fetch_count; otherwise fetch_count is tied to zero.
module instruction_fetch #(
  parameter int         DATA_W  = 16,
  parameter int         ADDR_W  = 6,
  parameter logic [3:0] HALT_OP = 4'hF
) (
  input  logic              clk,
  input  logic              res,
  input  logic              start,
  input  logic [ADDR_W-1:0] pc_addr,
  output logic              pc_en,
  input  logic              prog_we,
  input  logic [ADDR_W-1:0] prog_addr,
  input  logic [DATA_W-1:0] prog_data,
  output logic              instr_valid,
  input  logic              instr_ready,
  output logic [DATA_W-1:0] instr_data,
  output logic [ADDR_W-1:0] instr_addr,
  output logic              halted,
  output logic              busy,
  output logic [ADDR_W:0]   fetch_count
);

  localparam int DEPTH = 2 ** ADDR_W;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_STEP   = 3'd1;
  localparam logic [2:0] S_READ   = 3'd2;
  localparam logic [2:0] S_ISSUE  = 3'd3;
  localparam logic [2:0] S_HALTED = 3'd4;

  logic [2:0]        state;
  logic [2:0]        state_nxt;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [3:0]        opcode;
  logic              handshake;
  logic              last_word;

  assign opcode    = instr_data[DATA_W-1 -: 4];
  assign handshake = (state == S_ISSUE) && instr_ready;
  assign last_word = (opcode == HALT_OP) || (instr_addr == {ADDR_W{1'b1}});

  // Next-state logic for the fetch sequencer
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (start) state_nxt = S_STEP;
      S_STEP:   state_nxt = S_READ;
      S_READ:   state_nxt = S_ISSUE;
      S_ISSUE:  if (handshake) state_nxt = last_word ? S_HALTED : S_STEP;
      S_HALTED: state_nxt = S_HALTED;
      default:  state_nxt = S_IDLE;
    endcase
  end

  // State register; reset drops every state-decoded output at once
  always_ff @(posedge clk or negedge res) begin
    if (!res) state <= S_IDLE;
    else      state <= state_nxt;
  end

  // Program memory write port, unreset, open in every state
  always_ff @(posedge clk) begin
    if (prog_we) mem[prog_addr] <= prog_data;
  end

  // Capture the fetched word; NBA ordering gives read-before-write on collision
  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      instr_data <= '0;
      instr_addr <= '0;
    end else if (state == S_READ) begin
      instr_data <= mem[pc_addr];
      instr_addr <= pc_addr;
    end
  end

`ifdef FETCH_STATS_EN
  // Count accepted words, saturating at all-ones
  always_ff @(posedge clk or negedge res) begin
    if (!res)                               fetch_count <= '0;
    else if (handshake && !(&fetch_count))  fetch_count <= fetch_count + 1'b1;
  end
`else
  assign fetch_count = '0;
`endif

  assign pc_en       = (state == S_STEP);
  assign instr_valid = (state == S_ISSUE);
  assign halted      = (state == S_HALTED);
  assign busy        = (state == S_STEP) || (state == S_READ) || (state == S_ISSUE);

endmodule
